// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 multiplexer tree, RADIX inputs merged per registered stage.
// Valid/ready flow control with bubble collapse; a select >= N_IN flags err and forces zero data.
module mux_tree_pipe #(
  parameter  int WIDTH      = 8,
  parameter  int N_IN       = 64,
  parameter  int RADIX      = 4,
  localparam int SEL_W      = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int LOG_R      = (RADIX > 1) ? $clog2(RADIX) : 1,
  localparam int NUM_STAGES = (SEL_W + LOG_R - 1) / LOG_R
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SEL_P = NUM_STAGES * LOG_R;
  localparam int N_PAD = RADIX ** NUM_STAGES;

  if (RADIX < 2 || (RADIX & (RADIX - 1)) != 0) begin : g_bad_radix
    $error("mux_tree_pipe: RADIX must be a power of 2 and at least 2");
  end
  if (N_IN < 2) begin : g_bad_n_in
    $error("mux_tree_pipe: N_IN must be at least 2");
  end

  logic                    sel_oob;
  logic [N_PAD*WIDTH-1:0]  leaf;
  logic [NUM_STAGES:0]     load;
  logic [NUM_STAGES-1:0]   vld;

  // Extra bit keeps the compare from wrapping when N_IN is a power of 2.
  assign sel_oob = {1'b0, in_sel} >= (SEL_W + 1)'(N_IN);
  // Leaves past N_IN are zero; an out-of-range beat carries all-zero data down the tree.
  assign leaf    = sel_oob ? '0 : (N_PAD * WIDTH)'(in_data);

  // A stage loads when empty or when the stage after it loads.
  always_comb begin
    load             = '0;
    load[NUM_STAGES] = out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      load[k] = !vld[k] || load[k + 1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    localparam int N_OUT = N_PAD / (RADIX ** (k + 1));
    localparam int N_INP = N_OUT * RADIX;

    logic [N_INP*WIDTH-1:0] din;
    logic [SEL_W-1:0]       sel_in;
    logic                   err_in;
    logic                   vld_in;
    logic [LOG_R-1:0]       grp;
    logic [N_OUT*WIDTH-1:0] data_d, data_q;
    logic [SEL_W-1:0]       sel_d, sel_q;
    logic                   err_d, err_q;
    logic                   valid_d, valid_q;

    if (k == 0) begin : g_src
      assign din    = leaf;
      assign sel_in = in_sel;
      assign err_in = sel_oob;
      assign vld_in = in_valid;
    end else begin : g_src
      assign din    = g_stg[k-1].data_q;
      assign sel_in = g_stg[k-1].sel_q;
      assign err_in = g_stg[k-1].err_q;
      assign vld_in = g_stg[k-1].valid_q;
    end

    assign grp    = LOG_R'(SEL_P'(sel_in) >> (k * LOG_R));
    assign vld[k] = valid_q;

    always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      err_d   = err_q;
      valid_d = valid_q;
      if (load[k]) begin
        valid_d = vld_in;
        if (vld_in) begin
          sel_d = sel_in;
          err_d = err_in;
          for (int j = 0; j < N_OUT; j++) begin
            data_d[j*WIDTH +: WIDTH] = din[(j*RADIX + int'(grp))*WIDTH +: WIDTH];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        data_q  <= '0;
        sel_q   <= '0;
        err_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        sel_q   <= sel_d;
        err_q   <= err_d;
        valid_q <= valid_d;
      end
    end
  end

  assign out_data  = g_stg[NUM_STAGES-1].data_q;
  assign out_sel   = g_stg[NUM_STAGES-1].sel_q;
  assign out_err   = g_stg[NUM_STAGES-1].err_q;
  assign out_valid = g_stg[NUM_STAGES-1].valid_q;

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N-to-1 multiplexer tree; successor to the fixed 16:1 / 8:1 / 2:1 mux family.
- Generalised in input count, data width and per-stage radix.
- Adds registered tree levels with valid/ready flow control, bubble collapsing and out-of-range select detection.
- Used wherever a wide select (e.g. 64:1 channel pick) must close timing at the system clock.

Parameters:
WIDTH, 8, data bits per input and output
N_IN, 64, number of inputs (>=2; need not be a power of RADIX)
RADIX, 4, inputs merged per pipeline stage (power of 2, >=2)
SEL_W, $clog2(N_IN), select width (derived, not overridden)
NUM_STAGES, ceil(log2(N_IN)/log2(RADIX)), pipeline depth (derived; 3 for defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-high (asserted = 1; port name kept for family interface compatibility)
in_data  input  N_IN*WIDTH  packed inputs, input i at bits [i*WIDTH +: WIDTH]
in_sel  input  SEL_W  index of input to forward
in_valid  input  1  in_data/in_sel valid this cycle
in_ready  output  1  block accepts a transfer this cycle
out_data  output  WIDTH  selected data
out_sel  output  SEL_W  select value that produced out_data
out_err  output  1  in_sel was >= N_IN; out_data forced to 0
out_valid  output  1  out_* valid
out_ready  input  1  downstream accepts out_*

Behaviour:
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Stage k (k = 0..NUM_STAGES-1) resolves sel bits [k*log2(RADIX) +: log2(RADIX)], LSB group first.
  - Each stage registers the partially reduced data vector, the full sel, the err flag and a valid bit.
  - Unused tree leaves (index >= N_IN) are tied to 0.
- Stage k loads when its valid is 0 or stage k+1 loads (last stage: out_ready).
  - in_ready = stage-0 load condition, combinational from stage valids and out_ready only; no path from in_valid.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
- Latency: NUM_STAGES cycles from accepted input to out_valid with no backpressure.
  - Throughput: one transfer per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_data, out_sel and out_err hold stable.
  - Upstream stages fill; in_ready drops once all stages are valid.
  - Nothing is dropped or duplicated.
- Out-of-range select: in_sel >= N_IN sets err at stage 0; it propagates with the beat. out_err=1 and out_data=0 at the output; out_sel echoes the raw in_sel.
- Reset: while rst_n=1 at a rising edge, all stage valids and all data, sel and err registers clear.
  - Outputs next cycle: out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1 (in_ready is 1 from the first cycle after reset).
  - Reset mid-operation discards all in-flight beats.
  - A handshake coincident with the reset edge is not captured.
- Simultaneous input and output transfer with the pipeline full: each stage advances; no bubble is inserted.
- Data path is purely selective: no arithmetic and no width change. The sel comparison uses SEL_W+1 bits to avoid wrap when N_IN is a power of 2.
- Elaboration error when RADIX is not a power of 2 or N_IN < 2.

Test Plan:
- Reset, then defaults (N_IN=64, RADIX=4): drive in_data[i]=i+8'h40, in_sel=37, in_valid one cycle, out_ready=1 -> out_valid exactly 3 cycles later, out_data=8'h65, out_sel=37, out_err=0.
- Streaming: sel 0..63 on consecutive cycles, out_ready=1 -> 64 consecutive out beats, out_data=8'h40..8'h7F in order, in_ready constant 1.
- Backpressure: stream sel=5,6,7,8,9; hold out_ready=0 from cycle 2 for 6 cycles.
  - in_ready drops after the 3 stages fill.
  - out_data=8'h45 held stable through the stall.
  - On release: 8'h45..8'h49 in order, no loss or duplicate.
- N_IN=20, RADIX=4, WIDTH=16: in_sel=19 -> out_data=input 19, out_err=0.
  - in_sel=25 -> out_data=0, out_err=1, out_sel=25.
  - Latency 3 cycles.
- Reset mid-stream: assert rst_n=1 with 3 beats in flight -> next cycle out_valid=0, out_data=0, in_ready=1; no stale beat appears after reset release.
- RADIX=2, N_IN=16: in_sel=11 -> latency 4, correct data.
  - Random sel/valid/ready for 10k cycles checked against a reference model queue.
